// File: rtl/updown_counter_if.sv
// ---------------------------------------------------------------------------
// updown_counter_if
//   Control/status bundle between a bus-side controller and updown_counter.
//
//   Signals (controller -> counter):
//     en        count enable
//     down      1 = count down, 0 = count up
//     set       load `in` into the count register
//     in        load value for count and/or limit (WIDTH bits)
//     set_limit load `in` into the limit register
//     clr_ovf   clear the sticky overflow flag
//     oe        bus output enable for the tristate `out` pin
//   Signals (counter -> controller):
//     count     count register, always driven
//     limit     current terminal limit
//     wrap      one-cycle registered boundary-event pulse
//     ovf       sticky boundary-event flag
// ---------------------------------------------------------------------------
interface updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             down;
    logic             set;
    logic [WIDTH-1:0] in;
    logic             set_limit;
    logic             clr_ovf;
    logic             oe;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] limit;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, down, set, in, set_limit, clr_ovf, oe,
        input  count, limit, wrap, ovf
    );

    modport slave (
        input  en, down, set, in, set_limit, clr_ovf, oe,
        output count, limit, wrap, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// ---------------------------------------------------------------------------
// updown_counter
//   WIDTH-bit synchronous up/down counter with programmable terminal limit,
//   wrap or saturate behaviour at the boundaries, a registered boundary-event
//   pulse and a sticky overflow flag. The count is driven onto the shared bus
//   through a tristate pin and is also available, always driven, on bus.count.
//
//   Parameters:
//     WIDTH       counter / load / limit width (>= 2)
//     LIMIT_INIT  limit register value after reset
//     SATURATE    0 = wrap at boundaries, 1 = hold at boundaries
//
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    control/status bundle (slave side), see updown_counter_if
//     out    tristate bus pin: count when bus.oe = 1, high-impedance otherwise
// ---------------------------------------------------------------------------
module updown_counter #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] LIMIT_INIT = {WIDTH{1'b1}},
    parameter bit               SATURATE   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    updown_counter_if.slave    bus,
    // The shared bus pin is kept as a plain net so it can be resolved with
    // other drivers outside this block.
    output wire  [WIDTH-1:0]   out
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;
    logic             boundary;

    // -----------------------------------------------------------------------
    // Next-state logic. Count path priority: set > en-count > hold.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        count_d  = count_q;
        limit_d  = limit_q;
        boundary = 1'b0;

        if (bus.set) begin
            count_d = bus.in;
        end else if (bus.en && !bus.down) begin
            // >= rather than == so a count parked above the limit (after a
            // load or a lowered limit) still hits the boundary when counting up.
            if (count_q >= limit_q) begin
                boundary = 1'b1;
                count_d  = SATURATE ? count_q : '0;
            end else begin
                count_d  = count_q + 1'b1;
            end
        end else if (bus.en && bus.down) begin
            if (count_q == '0) begin
                boundary = 1'b1;
                count_d  = SATURATE ? '0 : limit_q;
            end else begin
                count_d  = count_q - 1'b1;
            end
        end

        // Limit path is independent of the count path; a new limit is only
        // seen by the comparisons above from the following edge.
        if (bus.set_limit) begin
            limit_d = bus.in;
        end

        wrap_d = boundary;
        // Setting has priority over clearing in the same cycle.
        ovf_d  = boundary | (ovf_q & ~bus.clr_ovf);
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so all registers update
        // together from values sampled before the edge.
        if (reset) begin
            count_q <= '0;
            limit_q <= LIMIT_INIT;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs.
    // -----------------------------------------------------------------------
    assign bus.count = count_q;
    assign bus.limit = limit_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;

    // Tristate response to oe is purely combinational and ignores reset.
    assign out = bus.oe ? count_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_counter
//   Two counters share a clock and reset: dut_w (wrap mode) and dut_s
//   (saturate mode). Each stimulus step updates a behavioural model, pushes
//   the expected register values to a scoreboard queue, and after the edge the
//   queue is drained and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_updown_counter;

    localparam int W = 8;

    typedef struct {
        int         sel;     // 0 = wrap-mode DUT, 1 = saturate-mode DUT
        logic [7:0] count;
        logic [7:0] limit;
        logic       wrap;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    wire  [W-1:0] out_w;
    wire  [W-1:0] out_s;

    updown_counter_if #(.WIDTH(W)) bus_w ();
    updown_counter_if #(.WIDTH(W)) bus_s ();

    updown_counter #(.WIDTH(W), .LIMIT_INIT(8'd255), .SATURATE(1'b0)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w),
        .out   (out_w)
    );

    updown_counter #(.WIDTH(W), .LIMIT_INIT(8'd255), .SATURATE(1'b1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s),
        .out   (out_s)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    logic [7:0] m_count[2];
    logic [7:0] m_limit[2];
    logic       m_ovf[2];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus_w.en = 1'b0; bus_w.down = 1'b0; bus_w.set = 1'b0;
        bus_w.set_limit = 1'b0; bus_w.clr_ovf = 1'b0; bus_w.in = '0;
        bus_s.en = 1'b0; bus_s.down = 1'b0; bus_s.set = 1'b0;
        bus_s.set_limit = 1'b0; bus_s.clr_ovf = 1'b0; bus_s.in = '0;
    endtask

    // Drain the scoreboard after an edge.
    task automatic compare();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                check("w_count", bus_w.count, e.count);
                check("w_limit", bus_w.limit, e.limit);
                check("w_wrap",  bus_w.wrap,  e.wrap);
                check("w_ovf",   bus_w.ovf,   e.ovf);
            end else begin
                check("s_count", bus_s.count, e.count);
                check("s_limit", bus_s.limit, e.limit);
                check("s_wrap",  bus_s.wrap,  e.wrap);
                check("s_ovf",   bus_s.ovf,   e.ovf);
            end
        end
    endtask

    // One clock of stimulus to one DUT (the other idles) with model update.
    task automatic step(input int sel, input logic en, input logic down,
                        input logic set, input logic set_limit,
                        input logic clr_ovf, input logic [7:0] din);
        exp_t       e;
        logic       ev;
        logic [7:0] nc;
        idle_inputs();
        if (sel == 0) begin
            bus_w.en = en; bus_w.down = down; bus_w.set = set;
            bus_w.set_limit = set_limit; bus_w.clr_ovf = clr_ovf; bus_w.in = din;
        end else begin
            bus_s.en = en; bus_s.down = down; bus_s.set = set;
            bus_s.set_limit = set_limit; bus_s.clr_ovf = clr_ovf; bus_s.in = din;
        end
        ev = 1'b0;
        nc = m_count[sel];
        if (set) begin
            nc = din;
        end else if (en) begin
            if (!down) begin
                if (m_count[sel] >= m_limit[sel]) begin
                    ev = 1'b1;
                    nc = (sel == 1) ? m_count[sel] : 8'd0;
                end else begin
                    nc = m_count[sel] + 8'd1;
                end
            end else begin
                if (m_count[sel] == 8'd0) begin
                    ev = 1'b1;
                    nc = (sel == 1) ? 8'd0 : m_limit[sel];
                end else begin
                    nc = m_count[sel] - 8'd1;
                end
            end
        end
        if (set_limit) m_limit[sel] = din;
        m_ovf[sel]   = ev | (m_ovf[sel] & ~clr_ovf);
        m_count[sel] = nc;
        e.sel = sel; e.count = nc; e.limit = m_limit[sel]; e.wrap = ev; e.ovf = m_ovf[sel];
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Reset both DUTs while every load/count input is active, so reset has
    // to override them.
    task automatic do_reset();
        exp_t e;
        reset = 1'b1;
        bus_w.en = 1'b1; bus_w.down = 1'b0; bus_w.set = 1'b1;
        bus_w.set_limit = 1'b1; bus_w.clr_ovf = 1'b0; bus_w.in = 8'hAA;
        bus_s.en = 1'b1; bus_s.down = 1'b1; bus_s.set = 1'b1;
        bus_s.set_limit = 1'b1; bus_s.clr_ovf = 1'b0; bus_s.in = 8'hAA;
        for (int s = 0; s < 2; s++) begin
            m_count[s] = 8'd0; m_limit[s] = 8'd255; m_ovf[s] = 1'b0;
            e.sel = s; e.count = 8'd0; e.limit = 8'd255; e.wrap = 1'b0; e.ovf = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        compare();
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus_w.oe = 1'b1;
        bus_s.oe = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Wrap mode, full range: 0..255 then back to 0 with one wrap pulse.
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 0, 0, 0, 0, 8'h00);
            check("out_follow", out_w, m_count[0]);
        end
        step(0, 0, 0, 0, 0, 0, 8'h00);           // hold: wrap drops, ovf sticks
        step(0, 0, 0, 0, 0, 1, 8'h00);           // clr_ovf alone clears

        // Limit 9: 0..9,0,1 then down from 0 reloads the limit.
        step(0, 0, 0, 1, 1, 0, 8'd9);            // set + set_limit together
        step(0, 0, 0, 1, 0, 0, 8'd0);
        for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 1, 0, 0, 8'd0);            // set wins over en/down
        step(0, 1, 1, 0, 0, 0, 8'h00);           // 0 -> 9, boundary
        step(0, 0, 0, 0, 0, 1, 8'h00);           // clear ovf
        step(0, 1, 0, 0, 0, 1, 8'h00);           // boundary + clr_ovf: set wins

        // Count above limit: set 50 with limit 20, counting up wraps to 0.
        step(0, 0, 0, 0, 1, 0, 8'd20);
        step(0, 0, 0, 1, 0, 0, 8'd50);
        step(0, 1, 1, 0, 0, 0, 8'h00);           // down from above limit: 49
        step(0, 1, 0, 0, 0, 0, 8'h00);           // up: boundary -> 0
        step(0, 1, 1, 1, 0, 0, 8'h33);           // load wins

        // Limit 0: every up edge is a boundary, count stays 0.
        step(0, 0, 0, 1, 1, 0, 8'd0);
        step(0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 0, 0, 0, 8'h00);

        // Bus tristate: released while counting, then follows count at once.
        step(0, 0, 0, 1, 1, 0, 8'd200);
        step(0, 0, 0, 1, 0, 0, 8'd100);
        bus_w.oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0, 8'h00);
            check("out_hiz", 32'(out_w !== m_count[0]), 32'd1);
        end
        bus_w.oe = 1'b1;
        #1;
        check("out_oe_comb", out_w, m_count[0]);

        // Saturate mode, limit 200.
        step(1, 0, 0, 1, 1, 0, 8'd200);
        step(1, 0, 0, 1, 0, 0, 8'd198);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 0, 0, 8'd1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 1, 8'h00);

        // Mixed random traffic on both counters.
        for (int i = 0; i < 80; i++) begin
            step(i % 2,
                 1'($urandom_range(3) != 0),
                 1'($urandom_range(1)),
                 1'($urandom_range(7) == 0),
                 1'($urandom_range(15) == 0),
                 1'($urandom_range(7) == 0),
                 8'($urandom_range(255)));
        end

        // Reset mid-count with concurrent load/limit/count requests.
        step(0, 1, 0, 0, 0, 0, 8'h00);
        do_reset();
        check("out_after_reset", out_w, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter for the 8-bit bus datapath: generalises the fixed 8-bit counter to WIDTH bits with a programmable terminal limit, wrap or saturate mode, count-enable, boundary-event pulse and sticky overflow flag. The count drives the shared bus through a tristate output gated by `oe` and is also available undriven-free on `count` for local logic.

## Interface
- `WIDTH`, 8: counter, load and limit width (≥2).
- `LIMIT_INIT`, 2**WIDTH-1: limit register value after reset.
- `SATURATE`, 0: 0 = wrap at boundaries, 1 = hold at boundaries.

- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable; no counting when low.
- `down` in 1: 1 = count down, 0 = count up.
- `set` in 1: load `in` into count.
- `in` in WIDTH: load value.
- `set_limit` in 1: load `in` into limit register.
- `clr_ovf` in 1: clear sticky `ovf`.
- `oe` in 1: bus output enable.
- `out` out WIDTH: count when `oe`=1, high-impedance otherwise (combinational).
- `count` out WIDTH: count register, always driven.
- `limit` out WIDTH: current limit register.
- `wrap` out 1: one-cycle pulse, registered, marks a boundary event.
- `ovf` out 1: sticky boundary-event flag.

## Operation
- Reset (sync, highest priority): count=0, limit=LIMIT_INIT, wrap=0, ovf=0. `out` still follows `oe`.
- Count update priority per edge: reset > set > en-count > hold.
  - `set`=1: count←`in` regardless of `en`/`down`; no boundary event.
  - else `en`=1, `down`=0: if count ≥ limit → boundary event; next = 0 (wrap) or count unchanged (saturate). Else count+1.
  - else `en`=1, `down`=1: if count = 0 → boundary event; next = limit (wrap) or 0 (saturate). Else count−1.
  - else hold.
- Limit update: `set_limit`=1 → limit←`in`, independent of count path; `set` and `set_limit` together load both from `in`. New limit takes effect for comparisons from the next edge.
- Count above limit (after load or limit lowered): counting up produces a boundary event on the next enabled edge (≥ compare); counting down decrements normally.
- Limit = 0: up-count from 0 is a boundary event every enabled edge; count stays 0 in both modes.
- `wrap`: registered; 1 in the cycle after an edge where a boundary event occurred, else 0. Saturating-hold edges still raise `wrap` on every such edge.
- `ovf`: set on boundary event; cleared by `clr_ovf`; boundary event and `clr_ovf` in the same edge → ovf=1 (set wins).
- All arithmetic modulo 2**WIDTH; no carry beyond WIDTH.

## Timing
- Count, limit, wrap, ovf: one-cycle latency from inputs sampled at rising `clk`.
- `out`, `count`, `limit` visible immediately after the edge; `out` tristate response to `oe` is combinational, zero cycles.
- Reset asserted mid-count: next edge forces all reset values, overriding concurrent `set`/`set_limit`/`en`.
- No handshakes; `en` may toggle every cycle.

## Test plan
- WIDTH=8, LIMIT_INIT=255, SATURATE=0: reset, en=1 up for 256 edges → count 0..255 then 0; wrap high exactly one cycle after the 255→0 edge; ovf=1 thereafter.
- set_limit with in=9, then up-count from 0 with en=1 → 0..9,0,1; down from 0 → 9; wrap pulse at each boundary.
- SATURATE=1, limit=200: set in=198, up → 199,200,200,200 with wrap high each hold cycle; down from 1 → 0,0 with wrap.
- set in=50 with limit=20, up → next count 0 (wrap mode); set and en and down together → load wins, count=in.
- oe=0 → out all Z while count advances; oe=1 → out equals count same cycle; clr_ovf alone clears ovf, clr_ovf concurrent with boundary keeps ovf=1.
- reset asserted with set=1,in=0xAA mid-count → count=0, limit=255, wrap=0, ovf=0 after that edge.
